lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_ram.sv | 32 +++
 rtl/lsu.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// LSU_MISALIGN_EN enables the BEAT2 state used by word-crossing RAM accesses.
package lsu_pkg;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic [1:0] MMIO_PREFIX_DEFAULT = 2'b11;

`ifdef LSU_MISALIGN_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT2 = 2'd1,
        PWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;
`endif

    function automatic logic size_ok(input logic [2:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
    endfunction

    // Byte lanes touched across two consecutive words; [7:4] belong to the next word.
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/lsu_ram.sv
// Unified instruction/data RAM: combinational fetch port, synchronous-read
// data port with per-byte write enables.
module lsu_ram #(
    parameter int unsigned DEPTH_WORDS = 512,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] fetch_idx,
    output logic [31:0]   fetch_data,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    assign fetch_data = mem[fetch_idx];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: routes requests to the local RAM or the MMIO port and
// returns one response per request. Define LSU_MISALIGN_EN to split word-crossing RAM accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [1:0]  MMIO_PREFIX = MMIO_PREFIX_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    output logic [15:0] iread,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_se,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] paddr,
    output logic [31:0] pwrite,
    output logic [2:0]  psize,
    output logic        pread_req,
    output logic        pwrite_req,
    input  logic [31:0] pread,
    input  logic        pack
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic        write_q, se_q, mmio_q, err_q;
    logic [31:0] addr_q, wdata_q, pdata_q;
    logic [2:0]  size_q;
`ifdef LSU_MISALIGN_EN
    logic        cross_q;
    logic [31:0] lo_q;
`endif

    logic        accept, req_mmio, req_cross, req_err;
    logic [7:0]  req_mask;
    logic [4:0]  req_sh;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_wdata, ram_rdata, fetch_word;

    logic [1:0]  rd_off;
    logic [31:0] rd_lo, rd_hi, raw, ext;
    logic        unused_iaddr;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_mask  = byte_mask(req_size, req_addr[1:0]);
    assign req_sh    = {req_addr[1:0], 3'b000};
    assign req_mmio  = (req_addr[31:30] == MMIO_PREFIX);
    assign req_cross = |req_mask[7:4];
`ifdef LSU_MISALIGN_EN
    assign req_err   = !size_ok(req_size);
`else
    assign req_err   = !size_ok(req_size) || (!req_mmio && req_cross);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_mmio) begin
                        state_d = PWAIT;
`ifdef LSU_MISALIGN_EN
                    end else if (req_cross) begin
                        state_d = BEAT2;
`endif
                    end else begin
                        state_d = RESP;
                    end
                end
            end
`ifdef LSU_MISALIGN_EN
            BEAT2:   state_d = RESP;
`endif
            PWAIT:   if (pack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first beat is driven straight from the request so it lands in the accept cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_idx   = req_addr[AW+1:2];
        ram_wdata = req_wdata << req_sh;
        if (accept && !req_err && !req_mmio) begin
            ram_en = 1'b1;
            if (req_write) ram_we = req_mask[3:0];
        end
`ifdef LSU_MISALIGN_EN
        if (state_q == BEAT2) begin
            ram_en    = 1'b1;
            ram_idx   = addr_q[AW+1:2] + AW'(1);
            ram_wdata = 32'(({32'b0, wdata_q} << {addr_q[1:0], 3'b000}) >> 32);
            if (write_q) ram_we = 4'(byte_mask(size_q, addr_q[1:0]) >> 4);
        end
`endif
    end

    always_comb begin
        rd_off = addr_q[1:0];
        rd_lo  = ram_rdata;
        rd_hi  = '0;
`ifdef LSU_MISALIGN_EN
        if (cross_q) begin
            rd_lo = lo_q;
            rd_hi = ram_rdata;
        end
`endif
        if (mmio_q) begin
            rd_off = 2'b00;
            rd_lo  = pdata_q;
            rd_hi  = '0;
        end
        raw = 32'({rd_hi, rd_lo} >> {rd_off, 3'b000});
        case (size_q)
            SIZE_B:  ext = {{24{se_q & raw[7]}}, raw[7:0]};
            SIZE_H:  ext = {{16{se_q & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            se_q    <= 1'b0;
            mmio_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            pdata_q <= '0;
`ifdef LSU_MISALIGN_EN
            cross_q <= 1'b0;
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                se_q    <= req_se;
                mmio_q  <= req_mmio;
                err_q   <= req_err;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
`ifdef LSU_MISALIGN_EN
                cross_q <= req_cross;
`endif
            end
`ifdef LSU_MISALIGN_EN
            if (state_q == BEAT2) lo_q <= ram_rdata;
`endif
            if (state_q == PWAIT && pack) pdata_q <= pread;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? ext : '0;

    assign pread_req  = (state_q == PWAIT) && !write_q;
    assign pwrite_req = (state_q == PWAIT) && write_q;
    assign paddr      = (state_q == PWAIT) ? addr_q : '0;
    assign pwrite     = (state_q == PWAIT) ? wdata_q : '0;
    assign psize      = (state_q == PWAIT) ? size_q : '0;

    lsu_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clock      (clock),
        .fetch_idx  (iaddr[AW+1:2]),
        .fetch_data (fetch_word),
        .en         (ram_en),
        .we         (ram_we),
        .idx        (ram_idx),
        .wdata      (ram_wdata),
        .rdata      (ram_rdata)
    );

    assign iread        = iaddr[1] ? fetch_word[31:16] : fetch_word[15:0];
    assign unused_iaddr = ^{iaddr[31:AW+2], iaddr[0]};

endmodule
